// File: rtl/fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter
// Shares the single frame-buffer read port (BRAM port B) between VGA scanout
// and the gesture-analysis engine. VGA always wins; analysis reads only in
// cycles VGA leaves free. An owner tag travels alongside each BRAM access so
// the returned word is steered to whoever issued it. Analysis waiting time is
// tracked per frame (longest wait, sticky starvation flag).
//
// Ports
//   clk25        in   pixel clock, sole clock
//   rst          in   synchronous active-high reset
//   frame_start  in   one-cycle pulse at start of frame (clears per-frame stats)
//   vga_req      in   VGA read request (absolute priority)
//   vga_addr     in   VGA read address
//   vga_pixel    out  returned VGA word (holds when not valid)
//   vga_valid    out  vga_pixel valid this cycle
//   ana_req      in   analysis read request
//   ana_addr     in   analysis address, stable while ana_req && !ana_gnt
//   ana_gnt      out  combinational accept for the analysis request
//   ana_data     out  returned analysis word (holds when not valid)
//   ana_valid    out  ana_data valid this cycle
//   ana_starve   out  sticky: wait reached STARVE_LIMIT this frame
//   ana_wait_max out  longest consecutive analysis wait this frame
//   mem_en       out  BRAM port-B enable
//   mem_addr     out  BRAM port-B address
//   mem_dout     in   BRAM port-B read data
// -----------------------------------------------------------------------------
module fb_read_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_pixel,
    output logic              vga_valid,
    input  logic              ana_req,
    input  logic [ADDR_W-1:0] ana_addr,
    output logic              ana_gnt,
    output logic [DATA_W-1:0] ana_data,
    output logic              ana_valid,
    output logic              ana_starve,
    output logic [15:0]       ana_wait_max,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VGA  = 2'd1,
        ST_ANA  = 2'd2
    } issue_state_e;

    // Limit widened by one bit so a limit of 65536 never truncates.
    localparam logic [16:0] STARVE_LIMIT_W = 17'(STARVE_LIMIT);

    // Saturating 16-bit increment for the wait counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    issue_state_e      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    // Owner tag per stage: bit 1 = VGA, bit 0 = analysis.
    logic [1:0]        tag_q [0:READ_LAT];
    logic [DATA_W-1:0] vga_pixel_q, ana_data_q;
    logic              vga_valid_q, ana_valid_q;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]       wait_max_q, wait_max_d;
    logic              starve_q, starve_d;
    logic              waiting_s;

    // Grant is purely combinational so a free cycle is used the same clock.
    assign ana_gnt   = ana_req & ~vga_req & ~rst;
    assign waiting_s = ana_req & ~ana_gnt;

    // Arbitration: pick the winner and the address to present next cycle.
    always_comb begin
        state_d    = ST_IDLE;
        mem_addr_d = mem_addr_q;
        if (vga_req) begin
            state_d = ST_VGA;
        end else if (ana_req) begin
            state_d = ST_ANA;
        end else begin
            state_d = ST_IDLE;
        end
        case (state_d)
            ST_VGA:  mem_addr_d = vga_addr;
            ST_ANA:  mem_addr_d = ana_addr;
            ST_IDLE: mem_addr_d = mem_addr_q;
            default: mem_addr_d = mem_addr_q;
        endcase
    end

    // Per-frame wait statistics; a frame_start clear beats any update.
    always_comb begin
        wait_cnt_d = 16'd0;
        wait_max_d = wait_max_q;
        starve_d   = starve_q;
        if (waiting_s) begin
            wait_cnt_d = sat_inc16(wait_cnt_q);
        end else begin
            wait_cnt_d = 16'd0;
        end
        if (frame_start) begin
            wait_max_d = 16'd0;
            starve_d   = 1'b0;
        end else begin
            if (wait_cnt_d > wait_max_q) begin
                wait_max_d = wait_cnt_d;
            end else begin
                wait_max_d = wait_max_q;
            end
            if ({1'b0, wait_cnt_d} >= STARVE_LIMIT_W) begin
                starve_d = 1'b1;
            end else begin
                starve_d = starve_q;
            end
        end
    end

    // Issue state and BRAM address register.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Owner tag shift register tracking each access through the BRAM latency.
    always_ff @(posedge clk25) begin
        if (rst) begin
            for (int i = 0; i <= READ_LAT; i++) begin
                tag_q[i] <= 2'b00;
            end
        end else begin
            tag_q[0] <= {state_d == ST_VGA, state_d == ST_ANA};
            for (int i = 1; i <= READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Return-data registers: only the tagged owner's data register loads.
    always_ff @(posedge clk25) begin
        if (rst) begin
            vga_pixel_q <= '0;
            vga_valid_q <= 1'b0;
            ana_data_q  <= '0;
            ana_valid_q <= 1'b0;
        end else begin
            vga_valid_q <= tag_q[READ_LAT][1];
            ana_valid_q <= tag_q[READ_LAT][0];
            if (tag_q[READ_LAT][1]) begin
                vga_pixel_q <= mem_dout;
            end
            if (tag_q[READ_LAT][0]) begin
                ana_data_q <= mem_dout;
            end
        end
    end

    // Wait-statistics registers.
    always_ff @(posedge clk25) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
            wait_max_q <= 16'd0;
            starve_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wait_max_q <= wait_max_d;
            starve_q   <= starve_d;
        end
    end

    assign mem_en       = (state_q != ST_IDLE);
    assign mem_addr     = mem_addr_q;
    assign vga_pixel    = vga_pixel_q;
    assign vga_valid    = vga_valid_q;
    assign ana_data     = ana_data_q;
    assign ana_valid    = ana_valid_q;
    assign ana_starve   = starve_q;
    assign ana_wait_max = wait_max_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
module tb_fb_read_arbiter;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int SL = 8;

    logic          clk25 = 1'b0;
    logic          rst = 1'b1, frame_start = 1'b0;
    logic          vga_req = 1'b0, ana_req = 1'b0;
    logic [AW-1:0] vga_addr = '0, ana_addr = '0;
    logic [DW-1:0] vga_pixel, ana_data;
    logic          vga_valid, ana_valid, ana_gnt, ana_starve, mem_en;
    logic [15:0]   ana_wait_max;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;

    always #5 clk25 = ~clk25;

    fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .STARVE_LIMIT(SL)) dut (
        .clk25(clk25), .rst(rst), .frame_start(frame_start),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_pixel(vga_pixel), .vga_valid(vga_valid),
        .ana_req(ana_req), .ana_addr(ana_addr), .ana_gnt(ana_gnt), .ana_data(ana_data),
        .ana_valid(ana_valid), .ana_starve(ana_starve), .ana_wait_max(ana_wait_max),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    // Frame-buffer content as a pure function of address.
    function automatic logic [15:0] bram_word(input logic [16:0] a);
        return (a[15:0] * 16'd37) ^ {a[16], 15'h1234};
    endfunction

    // BRAM port B, one cycle read latency.
    always @(posedge clk25) if (mem_en) mem_dout <= bram_word(mem_addr);

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          to_vga;
        logic [16:0] addr;
    } txn_t;
    txn_t        pend[$];
    int          edge_n = 0;
    bit          m_vv = 0, m_av = 0, m_starve = 0, m_mem_en = 0;
    logic [15:0] m_vpix = '0, m_adata = '0;
    logic [16:0] m_mem_addr = '0;
    int          m_cnt = 0, m_wmax = 0;

    int nerr = 0;
    int nchecks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model: an accepted read returns two edges later.
    task automatic model_edge();
        txn_t t;
        bit   vwin, awin;
        int   nc;
        if (rst) begin
            pend.delete();
            m_vv = 0; m_av = 0; m_vpix = '0; m_adata = '0;
            m_mem_en = 0; m_mem_addr = '0; m_cnt = 0; m_wmax = 0; m_starve = 0;
        end else begin
            m_vv = 0; m_av = 0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                t = pend.pop_front();
                if (t.to_vga) begin m_vv = 1; m_vpix = bram_word(t.addr); end
                else begin m_av = 1; m_adata = bram_word(t.addr); end
            end
            vwin = vga_req;
            awin = ana_req && !vga_req;
            if (vwin) begin
                t.due = edge_n + 2; t.to_vga = 1; t.addr = vga_addr;
                pend.push_back(t); m_mem_addr = vga_addr;
            end else if (awin) begin
                t.due = edge_n + 2; t.to_vga = 0; t.addr = ana_addr;
                pend.push_back(t); m_mem_addr = ana_addr;
            end
            m_mem_en = vwin || awin;
            nc = (ana_req && !awin) ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 0;
            m_cnt = nc;
            if (frame_start) begin
                m_wmax = 0; m_starve = 0;
            end else begin
                if (nc > m_wmax) m_wmax = nc;
                if (nc >= SL) m_starve = 1;
            end
        end
        edge_n++;
    endtask

    // One clock: check grant, take the edge, check registered outputs at negedge.
    task automatic tick();
        #1;
        chk("ana_gnt", 32'(ana_gnt), 32'(ana_req && !vga_req && !rst));
        @(posedge clk25);
        model_edge();
        @(negedge clk25);
        chk("vga_valid", 32'(vga_valid), 32'(m_vv));
        chk("ana_valid", 32'(ana_valid), 32'(m_av));
        chk("excl_valid", 32'(vga_valid && ana_valid), 32'd0);
        chk("vga_pixel", 32'(vga_pixel), 32'(m_vpix));
        chk("ana_data", 32'(ana_data), 32'(m_adata));
        chk("mem_en", 32'(mem_en), 32'(m_mem_en));
        chk("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
        chk("ana_wait_max", 32'(ana_wait_max), 32'(m_wmax));
        chk("ana_starve", 32'(ana_starve), 32'(m_starve));
    endtask

    initial begin
        int nv, na, first_v, k;
        bit g, hold;

        // 1: reset with both requests active
        rst = 1'b1; vga_req = 1'b1; ana_req = 1'b1;
        vga_addr = 17'h00005; ana_addr = 17'h00006;
        repeat (3) tick();
        #1 chk("rst_gnt", 32'(ana_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_valids", 32'({vga_valid, ana_valid}), 32'd0);
        chk("rst_wmax", 32'(ana_wait_max), 32'd0);
        chk("rst_starve", 32'(ana_starve), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // 2: VGA-only burst of addresses 0..9
        rst = 1'b0; ana_req = 1'b0; vga_req = 1'b1;
        nv = 0; na = 0; first_v = -1;
        for (int i = 0; i < 13; i++) begin
            vga_req = (i < 10);
            vga_addr = 17'(i);
            tick();
            if (vga_valid && first_v < 0) first_v = i;
            nv += int'(vga_valid); na += int'(ana_valid);
        end
        chk("t2_first_valid_idx", 32'(first_v), 32'd2);
        chk("t2_vga_pulses", 32'(nv), 32'd10);
        chk("t2_ana_pulses", 32'(na), 32'd0);

        // 3: contention for 5 cycles, then analysis granted
        vga_req = 1'b1; vga_addr = 17'h00100; ana_req = 1'b1; ana_addr = 17'h1ABCD;
        repeat (5) tick();
        chk("t3_wmax5", 32'(ana_wait_max), 32'd5);
        vga_req = 1'b0;
        tick();
        ana_req = 1'b0;
        tick();
        tick();
        chk("t3_ana_valid", 32'(ana_valid), 32'd1);
        chk("t3_ana_data", 32'(ana_data), 32'(bram_word(17'h1ABCD)));
        chk("t3_wmax_hold", 32'(ana_wait_max), 32'd5);
        repeat (2) tick();

        // 4: alternating VGA with continuous analysis requests
        nv = 0; na = 0; ana_req = 1'b1; ana_addr = 17'h02000;
        for (int i = 0; i < 12; i++) begin
            vga_req = (i % 2 == 0);
            vga_addr = 17'h03000 + 17'(i);
            g = ana_req && !vga_req;
            tick();
            nv += int'(vga_valid); na += int'(ana_valid);
            if (g) ana_addr = ana_addr + 17'd1;
        end
        ana_req = 1'b0; vga_req = 1'b0;
        repeat (3) begin
            tick();
            nv += int'(vga_valid); na += int'(ana_valid);
        end
        chk("t4_vga_pulses", 32'(nv), 32'd6);
        chk("t4_ana_pulses", 32'(na), 32'd6);

        // 5: starvation over 20 blocked cycles, then frame_start clears
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        vga_req = 1'b1; ana_req = 1'b1; ana_addr = 17'h04444; vga_addr = 17'h05555;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 7) chk("t5_starve_before", 32'(ana_starve), 32'd0);
            if (i == 8) chk("t5_starve_at_limit", 32'(ana_starve), 32'd1);
        end
        chk("t5_wmax20", 32'(ana_wait_max), 32'd20);
        vga_req = 1'b0; ana_req = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5_starve_clr", 32'(ana_starve), 32'd0);
        chk("t5_wmax_clr", 32'(ana_wait_max), 32'd0);
        repeat (2) tick();

        // 6: reset one cycle after an analysis grant kills the return
        ana_req = 1'b1; ana_addr = 17'h0F0F0;
        tick();
        ana_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_ana_valid", 32'(ana_valid), 32'd0);
        end

        // Random traffic, keeping ana_addr stable while a request waits
        for (int i = 0; i < 400; i++) begin
            hold = ana_req && (vga_req || rst);
            rst = ($urandom_range(0, 59) == 0);
            frame_start = ($urandom_range(0, 39) == 0);
            vga_req = ($urandom_range(0, 9) < 6);
            vga_addr = 17'($urandom_range(0, 76799));
            if (!hold) begin
                ana_req = ($urandom_range(0, 3) != 0);
                ana_addr = 17'($urandom_range(0, 76799));
            end
            tick();
        end
        rst = 1'b0; vga_req = 1'b0; ana_req = 1'b0; frame_start = 1'b0;
        for (k = 0; k < 4; k++) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
